// File: rtl/imem_loader.sv
// Instruction-memory program loader: framed little-endian byte stream in, word writes out.
// Verifies an XOR payload checksum and releases the processor on a good load.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              start_q, start_d;

    logic        accept;
    logic        idle_like;
    logic [15:0] len_word;
    logic        last_word;

    assign accept    = in_valid && in_ready;
    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
    assign len_word  = {len_q[15:8], in_data};
    assign last_word = (byte_cnt_q == 2'd3) && (word_cnt_q == 16'(len_q - 16'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            start_q    <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (load) state_d = S_LEN_HI;
            S_LEN_HI: if (accept) state_d = S_LEN_LO;
            S_LEN_LO: if (accept) begin
                if (len_word == 16'd0 || len_word > 16'(MAX_WORDS)) state_d = S_ERROR;
                else                                                 state_d = S_DATA;
            end
            S_DATA:  if (accept && last_word) state_d = S_CHECK;
            S_CHECK: if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates; the final word's write lands in the first CHECK cycle
    // independently of the checksum byte acceptance.
    always_comb begin
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        asm_d      = asm_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        start_d    = 1'b0;
        if (idle_like && load) begin
            len_d      = '0;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            csum_d     = '0;
            asm_d      = '0;
        end
        if (accept) begin
            case (state_q)
                S_LEN_HI: len_d[15:8] = in_data;
                S_LEN_LO: len_d[7:0]  = in_data;
                S_DATA: begin
                    csum_d     = csum_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: asm_d[7:0]   = in_data;
                        2'd1: asm_d[15:8]  = in_data;
                        2'd2: asm_d[23:16] = in_data;
                        default: begin
                            we_d       = 1'b1;
                            wdata_d    = {in_data, asm_q};
                            addr_d     = ADDR_W'({word_cnt_q, 2'b00});
                            word_cnt_d = word_cnt_q + 16'd1;
                        end
                    endcase
                end
                S_CHECK: start_d = (in_data == csum_q);
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_rst  = 1'b1;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign start    = start_q;

endmodule
